ms7200_link_monitor: RTL and testbench

- Runs after MS7200 HDMI-RX configuration completes.
- Periodically reads one MS7200 status register through the shared I2C driver and debounces the lock status.
- Raises a one-cycle re-initialisation request when the link stays lost.
- Runs in the I2C driver clock domain; requests the I2C bus from the top-level control block via a req/gnt handshake.

---
 rtl/ms72xx_pkg.sv | 21 ++
 rtl/ms72xx_poll_timer.sv | 33 +++
 rtl/ms7200_link_monitor.sv | 194 +++++++++++++++++++
 tb/tb_ms7200_link_monitor.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/ms72xx_pkg.sv
// Shared constants for the MS72xx HDMI bridge control blocks: FSM encoding,
// I2C slave addresses and transfer direction.
package ms72xx_pkg;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_WAIT      = 3'd1;
    localparam logic [2:0] ST_REQ       = 3'd2;
    localparam logic [2:0] ST_EXEC      = 3'd3;
    localparam logic [2:0] ST_WAIT_DONE = 3'd4;
    localparam logic [2:0] ST_EVAL      = 3'd5;
    localparam logic [2:0] ST_HOLD      = 3'd6;

    localparam logic [6:0] MS7200_SLV_ADDR = 7'h59;
    localparam logic [6:0] MS7210_SLV_ADDR = 7'h56;

    localparam logic I2C_DIR_RD = 1'b1;
    localparam logic I2C_DIR_WR = 1'b0;

    localparam logic [7:0] I2C_WDATA_NONE = 8'h00;

endpackage

// File: rtl/ms72xx_poll_timer.sv
// Loadable down-counter; tc is high while enabled and the count has reached zero.
module ms72xx_poll_timer #(
    parameter int W = 24
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         tc
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load)
            cnt_d = load_val;
        else if (en && (cnt_q != '0))
            cnt_d = cnt_q - 1'b1;
    end

    assign tc = en && !load && (cnt_q == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

endmodule

// File: rtl/ms7200_link_monitor.sv
// Periodic MS7200 lock-status poller: borrows the shared I2C driver, debounces
// the result and pulses reinit_req when the link stays lost.
module ms7200_link_monitor
    import ms72xx_pkg::*;
#(
    parameter logic [15:0] STATUS_ADDR    = 16'h0029,
    parameter logic [7:0]  STATUS_MASK    = 8'h01,
    parameter logic [7:0]  STATUS_EXP     = 8'h01,
    parameter logic [23:0] POLL_CYCLES    = 24'd250_000,
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd10_000,
    parameter logic [2:0]  FAIL_LIMIT     = 3'd3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        init_done,
    output logic        bus_req,
    input  logic        bus_gnt,
    output logic        i2c_exec,
    output logic        i2c_rh_wl,
    output logic [15:0] i2c_addr,
    output logic [7:0]  i2c_data_w,
    input  logic        i2c_done,
    input  logic        i2c_ack,
    input  logic [7:0]  i2c_data_r,
    output logic        link_ok,
    output logic [7:0]  status_byte,
    output logic        reinit_req,
    output logic        i2c_err
);

    logic [2:0] state_q, state_d;
    logic [2:0] fail_q, fail_d;
    logic [7:0] data_q, data_d;
    logic       ack_q, ack_d;
    logic       done_q, done_d;
    logic       abort_q, abort_d;
    logic       link_ok_q, link_ok_d;
    logic [7:0] status_q, status_d;
    logic       reinit_q, reinit_d;
    logic       err_q, err_d;

    logic       ivl_load, ivl_en, ivl_tc;
    logic       to_load, to_en, to_tc;
    logic [2:0] fail_inc;
    logic       abort_now;
    logic       success;

    ms72xx_poll_timer #(.W(24)) u_interval (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (ivl_load),
        .load_val (POLL_CYCLES - 24'd1),
        .en       (ivl_en),
        .tc       (ivl_tc)
    );

    ms72xx_poll_timer #(.W(16)) u_timeout (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (to_load),
        .load_val (TIMEOUT_CYCLES - 16'd1),
        .en       (to_en),
        .tc       (to_tc)
    );

    assign fail_inc  = (fail_q == FAIL_LIMIT) ? fail_q : fail_q + 3'd1;
    assign abort_now = abort_q || !init_done;
    assign success   = done_q && !ack_q && ((data_q & STATUS_MASK) == STATUS_EXP);

    always_comb begin
        state_d   = state_q;
        fail_d    = fail_q;
        data_d    = data_q;
        ack_d     = ack_q;
        done_d    = done_q;
        abort_d   = abort_q;
        link_ok_d = link_ok_q;
        status_d  = status_q;
        reinit_d  = 1'b0;
        err_d     = err_q;
        ivl_load  = 1'b0;
        ivl_en    = 1'b0;
        to_load   = 1'b0;
        to_en     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (init_done) begin
                    fail_d   = 3'd0;
                    ivl_load = 1'b1;
                    state_d  = ST_WAIT;
                end
            end
            ST_WAIT: begin
                ivl_en = 1'b1;
                if (!init_done)
                    state_d = ST_IDLE;
                else if (ivl_tc)
                    state_d = ST_REQ;
            end
            ST_REQ: begin
                if (!init_done)
                    state_d = ST_IDLE;
                else if (bus_gnt)
                    state_d = ST_EXEC;
            end
            ST_EXEC: begin
                to_load = 1'b1;
                abort_d = !init_done;
                done_d  = 1'b0;
                state_d = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                // a falling init_done only takes effect once the bus is free again
                to_en   = 1'b1;
                abort_d = abort_now;
                if (i2c_done) begin
                    done_d  = 1'b1;
                    ack_d   = i2c_ack;
                    data_d  = i2c_data_r;
                    err_d   = err_q || i2c_ack;
                    state_d = abort_now ? ST_IDLE : ST_EVAL;
                end else if (to_tc) begin
                    done_d  = 1'b0;
                    err_d   = 1'b1;
                    state_d = abort_now ? ST_IDLE : ST_EVAL;
                end
            end
            ST_EVAL: begin
                if (done_q && !ack_q)
                    status_d = data_q;
                if (success) begin
                    fail_d    = 3'd0;
                    link_ok_d = 1'b1;
                    ivl_load  = 1'b1;
                    state_d   = ST_WAIT;
                end else begin
                    fail_d = fail_inc;
                    if (fail_inc == FAIL_LIMIT) begin
                        link_ok_d = 1'b0;
                        reinit_d  = 1'b1;
                        state_d   = ST_HOLD;
                    end else begin
                        ivl_load = 1'b1;
                        state_d  = ST_WAIT;
                    end
                end
            end
            ST_HOLD: begin
                if (!init_done)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (!init_done)
            link_ok_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            fail_q    <= 3'd0;
            data_q    <= 8'h00;
            ack_q     <= 1'b0;
            done_q    <= 1'b0;
            abort_q   <= 1'b0;
            link_ok_q <= 1'b0;
            status_q  <= 8'h00;
            reinit_q  <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            fail_q    <= fail_d;
            data_q    <= data_d;
            ack_q     <= ack_d;
            done_q    <= done_d;
            abort_q   <= abort_d;
            link_ok_q <= link_ok_d;
            status_q  <= status_d;
            reinit_q  <= reinit_d;
            err_q     <= err_d;
        end
    end

    assign bus_req     = (state_q == ST_REQ) || (state_q == ST_EXEC) || (state_q == ST_WAIT_DONE);
    assign i2c_exec    = (state_q == ST_EXEC);
    assign i2c_rh_wl   = I2C_DIR_RD;
    assign i2c_addr    = STATUS_ADDR;
    assign i2c_data_w  = I2C_WDATA_NONE;
    assign link_ok     = link_ok_q;
    assign status_byte = status_q;
    assign reinit_req  = reinit_q;
    assign i2c_err     = err_q;

endmodule

// File: tb/tb_ms7200_link_monitor.sv
// Directed bench for ms7200_link_monitor with short poll/timeout intervals.
module tb_ms7200_link_monitor;

    localparam int P = 20;
    localparam int T = 30;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        init_done = 1'b0;
    logic        bus_req;
    logic        bus_gnt = 1'b1;
    logic        i2c_exec;
    logic        i2c_rh_wl;
    logic [15:0] i2c_addr;
    logic [7:0]  i2c_data_w;
    logic        i2c_done = 1'b0;
    logic        i2c_ack = 1'b0;
    logic [7:0]  i2c_data_r = 8'h00;
    logic        link_ok;
    logic [7:0]  status_byte;
    logic        reinit_req;
    logic        i2c_err;

    int checks = 0;
    int errors = 0;
    int exec_cnt = 0;
    int reinit_cnt = 0;
    int gnt_viol = 0;
    int n;
    int snap;

    ms7200_link_monitor #(
        .POLL_CYCLES    (24'(P)),
        .TIMEOUT_CYCLES (16'(T)),
        .FAIL_LIMIT     (3'd3)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .init_done   (init_done),
        .bus_req     (bus_req),
        .bus_gnt     (bus_gnt),
        .i2c_exec    (i2c_exec),
        .i2c_rh_wl   (i2c_rh_wl),
        .i2c_addr    (i2c_addr),
        .i2c_data_w  (i2c_data_w),
        .i2c_done    (i2c_done),
        .i2c_ack     (i2c_ack),
        .i2c_data_r  (i2c_data_r),
        .link_ok     (link_ok),
        .status_byte (status_byte),
        .reinit_req  (reinit_req),
        .i2c_err     (i2c_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (i2c_exec) begin
            exec_cnt++;
            if (!bus_gnt || !bus_req) gnt_viol++;
        end
        if (reinit_req) reinit_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
        end
    endtask

    // returns at the negedge where i2c_exec is seen high
    task automatic wait_exec(input int maxc, output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!i2c_exec && cyc < maxc);
        chk("exec_seen", i2c_exec, 1);
    endtask

    // called at the exec negedge; returns once EVAL has updated the outputs
    task automatic respond(input logic [7:0] d, input logic nack);
        @(negedge clk);
        i2c_done = 1'b1; i2c_data_r = d; i2c_ack = nack;
        @(negedge clk);
        i2c_done = 1'b0; i2c_ack = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        // reset state
        #1;
        chk("rst_bus_req", bus_req, 0);
        chk("rst_exec", i2c_exec, 0);
        chk("rst_rh_wl", i2c_rh_wl, 1);
        chk("rst_addr", i2c_addr, 16'h0029);
        chk("rst_wdata", i2c_data_w, 8'h00);
        chk("rst_link_ok", link_ok, 0);
        chk("rst_status", status_byte, 8'h00);
        chk("rst_reinit", reinit_req, 0);
        chk("rst_err", i2c_err, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_no_req", bus_req, 0);

        // first poll: latency and good status
        init_done = 1'b1;
        wait_exec(P + 10, n);
        chk("first_exec_latency", n, P + 2);
        chk("exec_bus_req", bus_req, 1);
        respond(8'h01, 1'b0);
        chk("good_link_ok", link_ok, 1);
        chk("good_status", status_byte, 8'h01);
        chk("good_bus_rel", bus_req, 0);
        chk("exec_once", exec_cnt, 1);

        // two failures then a success: no re-init, counter cleared
        wait_exec(P + 10, n);
        respond(8'h00, 1'b0);
        chk("f1_link_ok", link_ok, 1);
        chk("f1_status", status_byte, 8'h00);
        wait_exec(P + 10, n);
        respond(8'hFE, 1'b0);
        chk("f2_status", status_byte, 8'hFE);
        wait_exec(P + 10, n);
        respond(8'h81, 1'b0);
        chk("recover_link_ok", link_ok, 1);
        chk("recover_no_reinit", reinit_cnt, 0);

        // three failures in a row: re-init request
        wait_exec(P + 10, n);
        respond(8'h00, 1'b0);
        wait_exec(P + 10, n);
        respond(8'h00, 1'b0);
        chk("fc2_no_reinit", reinit_cnt, 0);
        chk("fc2_link_ok", link_ok, 1);
        wait_exec(P + 10, n);
        respond(8'h00, 1'b0);
        chk("fc3_reinit", reinit_req, 1);
        chk("fc3_link_ok", link_ok, 0);
        @(negedge clk);
        chk("reinit_one_cycle", reinit_req, 0);
        snap = exec_cnt;
        repeat (P + 20) @(negedge clk);
        chk("hold_no_exec", exec_cnt, snap);
        chk("reinit_count", reinit_cnt, 1);

        // re-init toggle, then a NACKed read
        init_done = 1'b0;
        @(negedge clk);
        init_done = 1'b1;
        wait_exec(P + 10, n);
        chk("reinit_exec_latency", n, P + 2);
        respond(8'h01, 1'b1);
        chk("nack_err", i2c_err, 1);
        chk("nack_status_kept", status_byte, 8'h00);
        chk("nack_link_ok", link_ok, 0);

        // grant withheld in REQ
        bus_gnt = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!bus_req && n < P + 10);
        chk("req_raised", bus_req, 1);
        snap = exec_cnt;
        repeat (500) @(negedge clk);
        chk("nogrant_no_exec", exec_cnt, snap);
        chk("nogrant_req_held", bus_req, 1);
        bus_gnt = 1'b1;
        @(negedge clk);
        chk("grant_exec", i2c_exec, 1);
        respond(8'h01, 1'b0);
        chk("grant_link_ok", link_ok, 1);
        chk("grant_status", status_byte, 8'h01);
        chk("err_sticky", i2c_err, 1);

        // init_done drops while the read is in flight
        wait_exec(P + 10, n);
        @(negedge clk);
        init_done = 1'b0;
        @(negedge clk);
        chk("abort_link_ok", link_ok, 0);
        chk("abort_req_held", bus_req, 1);
        i2c_done = 1'b1; i2c_data_r = 8'h00;
        @(negedge clk);
        i2c_done = 1'b0;
        chk("abort_bus_rel", bus_req, 0);
        chk("abort_status_kept", status_byte, 8'h01);
        snap = exec_cnt;
        repeat (P + 20) @(negedge clk);
        chk("abort_idle", exec_cnt, snap);

        // fresh reset, then a read that never completes
        rst_n = 1'b0;
        #1;
        chk("rst2_err", i2c_err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        init_done = 1'b1;
        wait_exec(P + 10, n);
        repeat (T) @(negedge clk);
        chk("to_err_before", i2c_err, 0);
        chk("to_req_before", bus_req, 1);
        @(negedge clk);
        chk("to_err_after", i2c_err, 1);
        chk("to_bus_rel", bus_req, 0);
        @(negedge clk);
        chk("to_link_ok", link_ok, 0);
        chk("to_no_reinit", reinit_req, 0);

        // async reset while EXEC is active
        wait_exec(P + 10, n);
        rst_n = 1'b0;
        #1;
        chk("arst_exec", i2c_exec, 0);
        chk("arst_bus_req", bus_req, 0);
        chk("arst_err", i2c_err, 0);
        chk("arst_status", status_byte, 8'h00);
        chk("gnt_rule", gnt_viol, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
